// File: rtl/rename_unit_pkg.sv
// Shared widths, tag types and reset images for the rename slice.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package rename_unit_pkg;

  localparam int NUM_PHY  = 64;
  localparam int NUM_ARCH = 32;
  localparam int PHY_W    = $clog2(NUM_PHY);
  localparam int ARCH_W   = $clog2(NUM_ARCH);
  localparam int FL_DEPTH = NUM_PHY - NUM_ARCH;
  localparam int FL_PTR_W = $clog2(FL_DEPTH);
  localparam int FL_CNT_W = FL_PTR_W + 1;

  typedef logic [PHY_W-1:0]  phy_tag_t;
  typedef logic [ARCH_W-1:0] arch_reg_t;

  // Packed so whole-table copies (flush restore, reset) are single assignments
  typedef phy_tag_t [NUM_ARCH-1:0] rat_t;
  typedef phy_tag_t [FL_DEPTH-1:0] fl_mem_t;

  localparam phy_tag_t ZERO_TAG = '0;

  // Architectural register r maps to physical register r out of reset
  function automatic rat_t identity_rat();
    rat_t m;
    for (int i = 0; i < NUM_ARCH; i++) m[i] = phy_tag_t'(i);
    return m;
  endfunction

  // Tags above the architectural range start out free, in ascending order
  function automatic fl_mem_t fl_reset_image();
    fl_mem_t m;
    for (int i = 0; i < FL_DEPTH; i++) m[i] = phy_tag_t'(NUM_ARCH + i);
    return m;
  endfunction

endpackage

// File: rtl/rename_unit_if.sv
// Decode-group, issue-window, wakeup and commit signals of the rename stage.
// Latency: n/a (wiring only).
// Backpressure: Stall from the window, Rename_stall back to decode.
interface rename_unit_if;
  import rename_unit_pkg::*;

  logic      flush;
  logic      Stall;
  logic      Rename_stall;

  logic      Inst1_Valid, Inst2_Valid;
  arch_reg_t Inst1_Rs, Inst1_Rt, Inst1_Rdst;
  arch_reg_t Inst2_Rs, Inst2_Rt, Inst2_Rdst;

  logic      RN_Inst1_Valid, RN_Inst2_Valid;
  phy_tag_t  RN_Inst1_Phydst, RN_Inst1_Src1, RN_Inst1_Src2;
  phy_tag_t  RN_Inst2_Phydst, RN_Inst2_Src1, RN_Inst2_Src2;
  logic      RN_Inst1_Src1_Wake, RN_Inst1_Src2_Wake;
  logic      RN_Inst2_Src1_Wake, RN_Inst2_Src2_Wake;

  logic      ALU0_Commit, ALU1_Commit, BU_Commit, DU_Commit;
  phy_tag_t  ALU0_Phydst, ALU1_Phydst, BU_Phydst, DU_Phydst;

  logic      Commit_1, Commit_2;
  phy_tag_t  Commit_Phy_1, Commit_Phy_2;
  arch_reg_t Commit_Rdst_1, Commit_Rdst_2;

  modport master (
    output flush, Stall,
    output Inst1_Valid, Inst2_Valid, Inst1_Rs, Inst1_Rt, Inst1_Rdst,
    output Inst2_Rs, Inst2_Rt, Inst2_Rdst,
    output ALU0_Commit, ALU1_Commit, BU_Commit, DU_Commit,
    output ALU0_Phydst, ALU1_Phydst, BU_Phydst, DU_Phydst,
    output Commit_1, Commit_2, Commit_Phy_1, Commit_Phy_2, Commit_Rdst_1, Commit_Rdst_2,
    input  Rename_stall,
    input  RN_Inst1_Valid, RN_Inst2_Valid,
    input  RN_Inst1_Phydst, RN_Inst1_Src1, RN_Inst1_Src2,
    input  RN_Inst2_Phydst, RN_Inst2_Src1, RN_Inst2_Src2,
    input  RN_Inst1_Src1_Wake, RN_Inst1_Src2_Wake, RN_Inst2_Src1_Wake, RN_Inst2_Src2_Wake
  );

  modport slave (
    input  flush, Stall,
    input  Inst1_Valid, Inst2_Valid, Inst1_Rs, Inst1_Rt, Inst1_Rdst,
    input  Inst2_Rs, Inst2_Rt, Inst2_Rdst,
    input  ALU0_Commit, ALU1_Commit, BU_Commit, DU_Commit,
    input  ALU0_Phydst, ALU1_Phydst, BU_Phydst, DU_Phydst,
    input  Commit_1, Commit_2, Commit_Phy_1, Commit_Phy_2, Commit_Rdst_1, Commit_Rdst_2,
    output Rename_stall,
    output RN_Inst1_Valid, RN_Inst2_Valid,
    output RN_Inst1_Phydst, RN_Inst1_Src1, RN_Inst1_Src2,
    output RN_Inst2_Phydst, RN_Inst2_Src1, RN_Inst2_Src2,
    output RN_Inst1_Src1_Wake, RN_Inst1_Src2_Wake, RN_Inst2_Src1_Wake, RN_Inst2_Src2_Wake
  );

endinterface

// File: rtl/rename_free_list.sv
// Circular free-tag FIFO: 2 pops at head, 2 pushes at tail, retire_head checkpoint for flush.
// Latency: pop data is combinational from head; pointer/count updates at the next edge.
// Backpressure: none internally; the caller must never pop more than count.
module rename_free_list
  import rename_unit_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic [1:0]          pop_cnt,
  input  logic                push1_vld,
  input  phy_tag_t            push1_dat,
  input  logic                push2_vld,
  input  phy_tag_t            push2_dat,
  output phy_tag_t            pop1_dat,
  output phy_tag_t            pop2_dat,
  output logic [FL_CNT_W-1:0] count
);

  fl_mem_t               fifo;
  logic [FL_PTR_W-1:0]   head, retire_head, tail;
  logic [FL_PTR_W-1:0]   head_p1, tail_2nd, tail_nxt, rhead_nxt;
  logic [1:0]            push_cnt;
  logic [FL_CNT_W-1:0]   restore_cnt;

  // Pointers are FL_DEPTH-wide (power of two), so modulo wrap is free
  assign head_p1   = head + FL_PTR_W'(1);
  assign pop1_dat  = fifo[head];
  assign pop2_dat  = fifo[head_p1];

  // A lone slot-2 push lands at tail; pushes are packed in commit order
  assign push_cnt  = {1'b0, push1_vld} + {1'b0, push2_vld};
  assign tail_2nd  = tail + FL_PTR_W'(push1_vld);
  assign tail_nxt  = tail + FL_PTR_W'(push_cnt);
  // Every retiring writer consumed one allocated entry, so retire_head tracks pushes
  assign rhead_nxt = retire_head + FL_PTR_W'(push_cnt);
  // Equal pointers after restore mean the whole committed free set is available
  assign restore_cnt = (tail_nxt == rhead_nxt) ? FL_CNT_W'(FL_DEPTH)
                                               : {1'b0, tail_nxt - rhead_nxt};

  // Storage, pointers and speculative count; flush rolls head back to the retire checkpoint
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fifo        <= fl_reset_image();
      head        <= '0;
      retire_head <= '0;
      tail        <= '0;
      count       <= FL_CNT_W'(FL_DEPTH);
    end else begin
      if (push1_vld) fifo[tail]     <= push1_dat;
      if (push2_vld) fifo[tail_2nd] <= push2_dat;
      tail        <= tail_nxt;
      retire_head <= rhead_nxt;
      if (flush) begin
        head  <= rhead_nxt;
        count <= restore_cnt;
      end else begin
        head  <= head + FL_PTR_W'(pop_cnt);
        count <= count + FL_CNT_W'(push_cnt) - FL_CNT_W'(pop_cnt);
      end
    end
  end

  // Pushing into a full list means a tag was freed twice or never allocated
  property p_no_overflow;
    @(posedge clk) disable iff (!rst)
      ((FL_CNT_W+1)'(count) + (FL_CNT_W+1)'(push_cnt)) <=
      ((FL_CNT_W+1)'(FL_DEPTH) + (FL_CNT_W+1)'(pop_cnt));
  endproperty
  a_no_overflow: assert property (p_no_overflow);

endmodule

// File: rtl/rename_unit.sv
// Two-wide rename: speculative/retirement RATs, ready table, free list, one output register.
// Latency: one cycle from accepted decode group to RN_* outputs.
// Backpressure: Rename_stall when free tags run short or Stall is high; RN_* hold under Stall.
module rename_unit
  import rename_unit_pkg::*;
(
  input logic         clk,
  input logic         rst,
  rename_unit_if.slave bus
);

  logic                alloc1, alloc2, do_rename;
  logic [1:0]          need;
  logic [FL_CNT_W-1:0] fl_count;
  phy_tag_t            fl_pop1, fl_pop2, new1, new2;

  logic                c1, c2;
  phy_tag_t            old1, old2;

  rat_t                srat, rrat, rrat_nxt;
  logic [NUM_PHY-1:0]  ready, wake_vec, ready_now;

  phy_tag_t            s11, s12, s21, s22;
  logic                w11, w12, w21, w22;
  logic                byp21, byp22;

  // Allocation demand and the stall seen by decode
  assign alloc1    = bus.Inst1_Valid && (bus.Inst1_Rdst != '0);
  assign alloc2    = bus.Inst1_Valid && bus.Inst2_Valid && (bus.Inst2_Rdst != '0);
  assign need      = {1'b0, alloc1} + {1'b0, alloc2};
  assign bus.Rename_stall = (FL_CNT_W'(need) > fl_count) || bus.Stall;
  assign do_rename = !bus.Rename_stall && !bus.flush;

  // Slot 2 takes the entry after whatever slot 1 consumed
  assign new1 = fl_pop1;
  assign new2 = alloc1 ? fl_pop2 : fl_pop1;

  // Wakeup strobes of this cycle, folded into the ready view; tag 0 is permanently ready
  always_comb begin
    wake_vec = '0;
    if (bus.ALU0_Commit) wake_vec[bus.ALU0_Phydst] = 1'b1;
    if (bus.ALU1_Commit) wake_vec[bus.ALU1_Phydst] = 1'b1;
    if (bus.BU_Commit)   wake_vec[bus.BU_Phydst]   = 1'b1;
    if (bus.DU_Commit)   wake_vec[bus.DU_Phydst]   = 1'b1;
  end
  assign ready_now = ready | wake_vec | NUM_PHY'(1);

  // Source lookup; slot 2 forwards slot 1's fresh tag, which cannot be ready yet
  assign byp21 = alloc1 && (bus.Inst2_Rs == bus.Inst1_Rdst);
  assign byp22 = alloc1 && (bus.Inst2_Rt == bus.Inst1_Rdst);
  assign s11   = srat[bus.Inst1_Rs];
  assign s12   = srat[bus.Inst1_Rt];
  assign s21   = byp21 ? new1 : srat[bus.Inst2_Rs];
  assign s22   = byp22 ? new1 : srat[bus.Inst2_Rt];
  assign w11   = ready_now[s11];
  assign w12   = ready_now[s12];
  assign w21   = !byp21 && ready_now[s21];
  assign w22   = !byp22 && ready_now[s22];

  // Retirement: the tag being overwritten is the one that becomes free
  assign c1   = bus.Commit_1 && (bus.Commit_Rdst_1 != '0);
  assign c2   = bus.Commit_2 && (bus.Commit_Rdst_2 != '0);
  assign old1 = rrat[bus.Commit_Rdst_1];
  assign old2 = (c1 && (bus.Commit_Rdst_2 == bus.Commit_Rdst_1)) ? bus.Commit_Phy_1
                                                                  : rrat[bus.Commit_Rdst_2];

  // Retirement RAT after this cycle's commits; also the flush restore image
  always_comb begin
    rrat_nxt = rrat;
    if (c1) rrat_nxt[bus.Commit_Rdst_1] = bus.Commit_Phy_1;
    if (c2) rrat_nxt[bus.Commit_Rdst_2] = bus.Commit_Phy_2;
  end

  rename_free_list u_fl (
    .clk       (clk),
    .rst       (rst),
    .flush     (bus.flush),
    .pop_cnt   (do_rename ? need : 2'd0),
    .push1_vld (c1),
    .push1_dat (old1),
    .push2_vld (c2),
    .push2_dat (old2),
    .pop1_dat  (fl_pop1),
    .pop2_dat  (fl_pop2),
    .count     (fl_count)
  );

  // Both RATs; a same-Rdst pair leaves slot 2's tag because its write comes last
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      srat <= identity_rat();
      rrat <= identity_rat();
    end else begin
      rrat <= rrat_nxt;
      if (bus.flush) begin
        srat <= rrat_nxt;
      end else if (do_rename) begin
        if (alloc1) srat[bus.Inst1_Rdst] <= new1;
        if (alloc2) srat[bus.Inst2_Rdst] <= new2;
      end
    end
  end

  // Ready table: wakeups set, fresh allocations clear, flush sets everything
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ready <= '1;
    end else if (bus.flush) begin
      ready <= '1;
    end else begin
      ready <= ready_now;
      if (do_rename && alloc1) ready[new1] <= 1'b0;
      if (do_rename && alloc2) ready[new2] <= 1'b0;
    end
  end

  // Output register: load on accept, hold under Stall while still catching wakeups
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.RN_Inst1_Valid     <= 1'b0;
      bus.RN_Inst2_Valid     <= 1'b0;
      bus.RN_Inst1_Phydst    <= ZERO_TAG;
      bus.RN_Inst1_Src1      <= ZERO_TAG;
      bus.RN_Inst1_Src2      <= ZERO_TAG;
      bus.RN_Inst2_Phydst    <= ZERO_TAG;
      bus.RN_Inst2_Src1      <= ZERO_TAG;
      bus.RN_Inst2_Src2      <= ZERO_TAG;
      bus.RN_Inst1_Src1_Wake <= 1'b0;
      bus.RN_Inst1_Src2_Wake <= 1'b0;
      bus.RN_Inst2_Src1_Wake <= 1'b0;
      bus.RN_Inst2_Src2_Wake <= 1'b0;
    end else if (bus.flush) begin
      bus.RN_Inst1_Valid <= 1'b0;
      bus.RN_Inst2_Valid <= 1'b0;
    end else if (bus.Stall) begin
      bus.RN_Inst1_Src1_Wake <= bus.RN_Inst1_Src1_Wake | wake_vec[bus.RN_Inst1_Src1];
      bus.RN_Inst1_Src2_Wake <= bus.RN_Inst1_Src2_Wake | wake_vec[bus.RN_Inst1_Src2];
      bus.RN_Inst2_Src1_Wake <= bus.RN_Inst2_Src1_Wake | wake_vec[bus.RN_Inst2_Src1];
      bus.RN_Inst2_Src2_Wake <= bus.RN_Inst2_Src2_Wake | wake_vec[bus.RN_Inst2_Src2];
    end else if (do_rename) begin
      bus.RN_Inst1_Valid     <= bus.Inst1_Valid;
      bus.RN_Inst2_Valid     <= bus.Inst1_Valid && bus.Inst2_Valid;
      bus.RN_Inst1_Phydst    <= alloc1 ? new1 : ZERO_TAG;
      bus.RN_Inst2_Phydst    <= alloc2 ? new2 : ZERO_TAG;
      bus.RN_Inst1_Src1      <= s11;
      bus.RN_Inst1_Src2      <= s12;
      bus.RN_Inst2_Src1      <= s21;
      bus.RN_Inst2_Src2      <= s22;
      bus.RN_Inst1_Src1_Wake <= w11;
      bus.RN_Inst1_Src2_Wake <= w12;
      bus.RN_Inst2_Src1_Wake <= w21;
      bus.RN_Inst2_Src2_Wake <= w22;
    end else begin
      bus.RN_Inst1_Valid <= 1'b0;
      bus.RN_Inst2_Valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rename_unit.sv
// Directed bench for rename_unit: hand-computed tags for allocation, bypass, wrap, commit, flush, reset.
// Latency: checks one edge after each driven group.
// Backpressure: exercises Stall hold and free-list exhaustion.
module tb_rename_unit;
  import rename_unit_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  rename_unit_if bus ();

  rename_unit u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.flush = 1'b0;  bus.Stall = 1'b0;
    bus.Inst1_Valid = 1'b0; bus.Inst1_Rs = '0; bus.Inst1_Rt = '0; bus.Inst1_Rdst = '0;
    bus.Inst2_Valid = 1'b0; bus.Inst2_Rs = '0; bus.Inst2_Rt = '0; bus.Inst2_Rdst = '0;
    bus.ALU0_Commit = 1'b0; bus.ALU1_Commit = 1'b0; bus.BU_Commit = 1'b0; bus.DU_Commit = 1'b0;
    bus.ALU0_Phydst = '0; bus.ALU1_Phydst = '0; bus.BU_Phydst = '0; bus.DU_Phydst = '0;
    bus.Commit_1 = 1'b0; bus.Commit_2 = 1'b0;
    bus.Commit_Phy_1 = '0; bus.Commit_Phy_2 = '0; bus.Commit_Rdst_1 = '0; bus.Commit_Rdst_2 = '0;
  endtask

  task automatic grp(input logic v1, input arch_reg_t rs1, input arch_reg_t rt1, input arch_reg_t rd1,
                     input logic v2, input arch_reg_t rs2, input arch_reg_t rt2, input arch_reg_t rd2);
    bus.Inst1_Valid = v1; bus.Inst1_Rs = rs1; bus.Inst1_Rt = rt1; bus.Inst1_Rdst = rd1;
    bus.Inst2_Valid = v2; bus.Inst2_Rs = rs2; bus.Inst2_Rt = rt2; bus.Inst2_Rdst = rd2;
  endtask

  task automatic do_reset();
    idle();
    @(negedge clk); rst = 1'b0;
    @(negedge clk); rst = 1'b1;
  endtask

  initial begin
    arch_reg_t rd;
    idle();
    rst = 1'b0;
    repeat (2) tick();

    // Reset state
    chk("rst_rn1_valid", bus.RN_Inst1_Valid, 0);
    chk("rst_rn2_valid", bus.RN_Inst2_Valid, 0);
    chk("rst_rn1_dst", bus.RN_Inst1_Phydst, 0);
    chk("rst_rn2_wake", bus.RN_Inst2_Src1_Wake, 0);
    chk("rst_count", u_dut.u_fl.count, 32);
    chk("rst_stall", bus.Rename_stall, 0);

    // Basic dual allocation
    @(negedge clk); rst = 1'b1;
    grp(1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 5'd1, 5'd2, 5'd6);
    #1 chk("A_stall", bus.Rename_stall, 0);
    tick();
    chk("A_rn1_valid", bus.RN_Inst1_Valid, 1);
    chk("A_rn1_dst", bus.RN_Inst1_Phydst, 32);
    chk("A_rn1_src1", bus.RN_Inst1_Src1, 1);
    chk("A_rn1_src2", bus.RN_Inst1_Src2, 2);
    chk("A_rn1_wake1", bus.RN_Inst1_Src1_Wake, 1);
    chk("A_rn1_wake2", bus.RN_Inst1_Src2_Wake, 1);
    chk("A_rn2_valid", bus.RN_Inst2_Valid, 1);
    chk("A_rn2_dst", bus.RN_Inst2_Phydst, 33);
    chk("A_rn2_src1", bus.RN_Inst2_Src1, 1);
    chk("A_rn2_src2", bus.RN_Inst2_Src2, 2);
    chk("A_rn2_wake1", bus.RN_Inst2_Src1_Wake, 1);
    chk("A_rn2_wake2", bus.RN_Inst2_Src2_Wake, 1);
    idle();
    tick();
    chk("A_idle_valid", bus.RN_Inst1_Valid, 0);

    // Intra-group bypass, then wakeup while held
    do_reset();
    grp(1'b1, 5'd0, 5'd0, 5'd7, 1'b1, 5'd7, 5'd3, 5'd0);
    tick();
    chk("B_rn1_dst", bus.RN_Inst1_Phydst, 32);
    chk("B_rn1_wake_r0", bus.RN_Inst1_Src1_Wake, 1);
    chk("B_rn2_src1", bus.RN_Inst2_Src1, 32);
    chk("B_rn2_src1_wake", bus.RN_Inst2_Src1_Wake, 0);
    chk("B_rn2_src2", bus.RN_Inst2_Src2, 3);
    chk("B_rn2_src2_wake", bus.RN_Inst2_Src2_Wake, 1);
    chk("B_rn2_dst", bus.RN_Inst2_Phydst, 0);
    idle();
    bus.Stall = 1'b1;
    #1 chk("B_stall_out", bus.Rename_stall, 1);
    tick();
    chk("B_hold_valid", bus.RN_Inst1_Valid, 1);
    chk("B_hold_wake", bus.RN_Inst2_Src1_Wake, 0);
    bus.ALU0_Commit = 1'b1; bus.ALU0_Phydst = 6'd32;
    tick();
    chk("B_woken_wake", bus.RN_Inst2_Src1_Wake, 1);
    chk("B_woken_src", bus.RN_Inst2_Src1, 32);
    chk("B_hold_valid2", bus.RN_Inst2_Valid, 1);
    bus.ALU0_Commit = 1'b0; bus.Stall = 1'b0;
    tick();
    chk("B_release_valid", bus.RN_Inst1_Valid, 0);

    // Exhaust the free list, free one tag, see it come back after wrap
    do_reset();
    for (int i = 0; i < 16; i++) begin
      rd = (i == 0) ? 5'd5 : 5'd8;
      grp(1'b1, 5'd0, 5'd0, rd, 1'b1, 5'd0, 5'd0, 5'd9);
      tick();
      chk("C_dst1", bus.RN_Inst1_Phydst, 32 + 2*i);
      chk("C_dst2", bus.RN_Inst2_Phydst, 33 + 2*i);
    end
    chk("C_count_empty", u_dut.u_fl.count, 0);
    grp(1'b1, 5'd0, 5'd0, 5'd10, 1'b0, 5'd0, 5'd0, 5'd0);
    #1 chk("C_stall_full", bus.Rename_stall, 1);
    tick();
    chk("C_no_load", bus.RN_Inst1_Valid, 0);
    bus.Commit_1 = 1'b1; bus.Commit_Rdst_1 = 5'd5; bus.Commit_Phy_1 = 6'd32;
    #1 chk("C_stall_commit_cycle", bus.Rename_stall, 1);
    tick();
    bus.Commit_1 = 1'b0;
    #1 chk("C_stall_dropped", bus.Rename_stall, 0);
    chk("C_count_one", u_dut.u_fl.count, 1);
    tick();
    chk("C_wrap_valid", bus.RN_Inst1_Valid, 1);
    chk("C_wrap_dst", bus.RN_Inst1_Phydst, 5);
    idle();

    // Same-Rdst pair, partial commit, flush restore
    do_reset();
    grp(1'b1, 5'd0, 5'd0, 5'd3, 1'b1, 5'd0, 5'd0, 5'd3);
    tick();
    chk("D_dst1", bus.RN_Inst1_Phydst, 32);
    chk("D_dst2", bus.RN_Inst2_Phydst, 33);
    idle();
    bus.Commit_1 = 1'b1; bus.Commit_Rdst_1 = 5'd3; bus.Commit_Phy_1 = 6'd32;
    bus.flush = 1'b1;
    tick();
    chk("D_flush_valid", bus.RN_Inst1_Valid, 0);
    chk("D_flush_count", u_dut.u_fl.count, 32);
    idle();
    grp(1'b1, 5'd3, 5'd3, 5'd4, 1'b1, 5'd3, 5'd0, 5'd0);
    tick();
    chk("D_src_restored", bus.RN_Inst1_Src1, 32);
    chk("D_next_alloc", bus.RN_Inst1_Phydst, 33);
    chk("D_wake11", bus.RN_Inst1_Src1_Wake, 1);
    chk("D_wake12", bus.RN_Inst1_Src2_Wake, 1);
    chk("D_wake21", bus.RN_Inst2_Src1_Wake, 1);
    chk("D_wake22", bus.RN_Inst2_Src2_Wake, 1);
    chk("D_rn2_src1", bus.RN_Inst2_Src1, 32);
    idle();

    // Dual commit to the same Rdst
    do_reset();
    for (int i = 0; i < 10; i++) begin
      grp(1'b1, 5'd0, 5'd0, 5'd4, 1'b1, 5'd0, 5'd0, 5'd4);
      tick();
    end
    chk("E_last_dst2", bus.RN_Inst2_Phydst, 51);
    idle();
    bus.Commit_1 = 1'b1; bus.Commit_Rdst_1 = 5'd4; bus.Commit_Phy_1 = 6'd40;
    bus.Commit_2 = 1'b1; bus.Commit_Rdst_2 = 5'd4; bus.Commit_Phy_2 = 6'd41;
    tick();
    idle();
    chk("E_count_plus2", u_dut.u_fl.count, 14);
    for (int i = 0; i < 6; i++) begin
      grp(1'b1, 5'd0, 5'd0, 5'd4, 1'b1, 5'd0, 5'd0, 5'd4);
      tick();
    end
    chk("E_count_low", u_dut.u_fl.count, 2);
    chk("E_pre_wrap_dst2", bus.RN_Inst2_Phydst, 63);
    tick();
    chk("E_freed1", bus.RN_Inst1_Phydst, 4);
    chk("E_freed2", bus.RN_Inst2_Phydst, 40);
    idle();
    bus.flush = 1'b1;
    tick();
    idle();
    grp(1'b1, 5'd4, 5'd0, 5'd0, 1'b0, 5'd0, 5'd0, 5'd0);
    tick();
    chk("E_rrat4", bus.RN_Inst1_Src1, 41);
    chk("E_nowrite_dst", bus.RN_Inst1_Phydst, 0);
    idle();

    // Reset mid-stream
    do_reset();
    for (int i = 0; i < 3; i++) begin
      grp(1'b1, 5'd0, 5'd0, 5'd5, 1'b1, 5'd0, 5'd0, 5'd6);
      tick();
    end
    idle();
    chk("F_pre_valid", bus.RN_Inst1_Valid, 1);
    chk("F_pre_count", u_dut.u_fl.count, 26);
    @(negedge clk); rst = 1'b0;
    #1;
    chk("F_rst_valid", bus.RN_Inst1_Valid, 0);
    chk("F_rst_dst", bus.RN_Inst1_Phydst, 0);
    chk("F_rst_count", u_dut.u_fl.count, 32);
    @(negedge clk); rst = 1'b1;
    grp(1'b1, 5'd5, 5'd6, 5'd5, 1'b0, 5'd0, 5'd0, 5'd0);
    tick();
    chk("F_identity_src1", bus.RN_Inst1_Src1, 5);
    chk("F_identity_src2", bus.RN_Inst1_Src2, 6);
    chk("F_first_alloc", bus.RN_Inst1_Phydst, 32);
    idle();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/rename_unit.md
Name: rename_unit

Overview:
- Two-wide register rename stage sitting directly upstream of the issue window.
- Maps 5-bit architectural registers to 6-bit physical tags using a speculative RAT, a retirement RAT, a free-list FIFO and a ready table.
- Delivers renamed Phydst/Src1/Src2 plus wake bits to the issue window through one pipeline register.
- Consumes the window's in-order Commit_1/Commit_2 stream to recycle physical tags, and restores state on flush.

Parameters:
- NUM_PHY, 64, number of physical registers; tag width is $clog2(NUM_PHY).
- NUM_ARCH, 32, number of architectural registers.
- FL_DEPTH, NUM_PHY-NUM_ARCH, free-list capacity (32).

Ports:
- clk  input  1  clock
- rst  input  1  reset; asynchronous, active-low
- flush  input  1  discard all speculative state
- Stall  input  1  issue window full; output register holds
- Inst1_Valid, Inst2_Valid  input  1 each  decode slot valid (Inst2 only meaningful with Inst1)
- Inst1_Rs, Inst1_Rt, Inst1_Rdst  input  5 each  slot-1 architectural sources and destination (Rdst=0: no write)
- Inst2_Rs, Inst2_Rt, Inst2_Rdst  input  5 each  slot-2 architectural sources and destination
- Rename_stall  output  1  combinational; decode must hold its group
- RN_Inst1_Valid, RN_Inst2_Valid  output  1 each  registered valid to issue window
- RN_Inst1_Phydst, RN_Inst1_Src1, RN_Inst1_Src2  output  6 each  slot-1 renamed tags
- RN_Inst2_Phydst, RN_Inst2_Src1, RN_Inst2_Src2  output  6 each  slot-2 renamed tags
- RN_Inst1_Src1_Wake, RN_Inst1_Src2_Wake, RN_Inst2_Src1_Wake, RN_Inst2_Src2_Wake  output  1 each  source ready
- ALU0_Commit, ALU1_Commit, BU_Commit, DU_Commit  input  1 each  wakeup strobes
- ALU0_Phydst, ALU1_Phydst, BU_Phydst, DU_Phydst  input  6 each  wakeup tags
- Commit_1, Commit_2  input  1 each  in-order retirement; Commit_2 implies Commit_1
- Commit_Phy_1, Commit_Phy_2  input  6 each  retiring physical destinations
- Commit_Rdst_1, Commit_Rdst_2  input  5 each  retiring architectural destinations

Behaviour:
- Reset (async, rst=0):
  - Both RATs are identity (arch r -> phys r).
  - Free list holds tags 32..63 in ascending order: head=retire_head=0, tail=0, count=32.
  - All ready bits are 1.
  - All RN_* outputs are 0.
- Allocation:
  - A slot allocates when it is valid and Rdst!=0.
  - Slot 1 pops free-list[head]; slot 2 pops the next entry.
  - Non-writing slots output Phydst=0.
- Rename_stall = (allocations needed > speculative count) | Stall. When asserted, nothing is renamed or popped.
- Sources: read from the speculative RAT.
  - An Inst2 source equal to Inst1_Rdst (Rdst!=0) takes Inst1's new tag with Wake=0.
  - If both slots write the same Rdst, the RAT gets Inst2's tag.
- Wake bit = ready[tag] | any wakeup strobe whose tag matches this cycle. Tag 0 is always ready.
- Allocated tags have ready cleared at the same edge the RAT is written.
- Latency: one cycle from accepted decode group to RN_* outputs.
  - If Stall is high, RN_* hold their values.
  - Held Wake bits still OR in matching wakeup tags every cycle, so no wakeup is lost.
  - A valid group accepted while Stall=0 loads the register; otherwise RN_Inst*_Valid=0.
- Commit, per retiring slot with Rdst!=0:
  - old = retirement RAT[Rdst]; retirement RAT[Rdst] <= Commit_Phy.
  - Push old at tail; retire_head advances by 1.
  - For two commits to the same Rdst, slot 2's old tag is slot 1's Commit_Phy.
  - Pushes and pops in the same cycle both apply: count += pushes - pops.
- Wrap-around: head, retire_head and tail are modulo FL_DEPTH. Count never exceeds FL_DEPTH; a push at count=FL_DEPTH is an assertion failure.
- Flush (overrides allocation in that cycle; same-cycle commits still apply):
  - speculative RAT <= retirement RAT (including this cycle's commit writes).
  - head <= retire_head after this cycle's commits; speculative count = tail - retire_head.
  - All ready bits set; RN_* valids cleared.
- Reset mid-operation returns every structure to its reset value immediately.

Decomposition:
- Shared package holds:
  - PHY_W=6, ARCH_W=5, NUM_PHY, NUM_ARCH.
  - Tag typedef.
  - Constant ZERO_TAG.
- One sub-module: rename_free_list, a circular FIFO with 2-pop, 2-push, a checkpointed retire_head and flush restore.
- RAT, ready table and output register stay in rename_unit.

Test Plan:
- After reset, rename Inst1 Rdst=5, Inst2 Rdst=6 with sources 1,2 -> RN_Inst1_Phydst=32, RN_Inst2_Phydst=33, Src1=1, Src2=2, all Wake=1.
- Inst1 Rdst=7 and Inst2 Rs=7 in the same group -> RN_Inst2_Src1 = Inst1's tag 32, RN_Inst2_Src1_Wake=0. Then pulse ALU0_Commit with tag 32 while Stall=1 -> held Wake becomes 1.
- Allocate 32 tags with no commits -> the 33rd writing instruction sees Rename_stall=1. Commit_1 Rdst=5 -> old tag 5 freed, stall drops next cycle, and the next allocation eventually returns tag 5 after wrap.
- Rename r3->32, r3->33; commit the first only; flush -> speculative RAT[3]=32, next allocation returns 33, and all Wake bits are 1.
- Dual commit, both Rdst=4, Phy 40 and 41 -> freed tags are 4 then 40; retirement RAT[4]=41; count +2.
- Pull rst low mid-stream with the free list partially drained -> outputs immediately 0, count=32, identity RAT.
